// File: rtl/booth_lane_array.sv
`timescale 1ns/1ps
// Purpose    : LANES lock-step radix-4 Booth multipliers (N x N -> 2N, signed or unsigned).
// Latency    : done pulses N/2+2 cycles after the start-sampling edge; one result per N/2+2 cycles.
// Backpressure: none; start is ignored while busy, accepted again in IDLE or in the DONE cycle.
// Ports: clk/rst_n (async active-low); start, signed_mode, lane_en sampled on acceptance;
//        multiplicand/multiplier lane i at [i*N +: N]; busy/done status;
//        products lane i at [i*2N +: 2N]; product_sel = products lane sel (0 if sel >= LANES).
module booth_lane_array #(
    parameter int N     = 16,
    parameter int LANES = 4,
    localparam int SW   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   signed_mode,
    input  logic [LANES-1:0]       lane_en,
    input  logic [LANES*N-1:0]     multiplicand,
    input  logic [LANES*N-1:0]     multiplier,
    input  logic [SW-1:0]          sel,
    output logic                   busy,
    output logic                   done,
    output logic [LANES*2*N-1:0]   products,
    output logic [2*N-1:0]         product_sel
);
    // Operands are widened by two bits so both signed and unsigned N-bit
    // values are exact signed (N+2)-bit numbers; that also gives an even
    // digit count of (N+2)/2 = N/2+1 Booth digits.
    localparam int XW     = N + 2;
    localparam int HW     = N + 4;        // upper accumulator: +-2x multiplicand plus guard
    localparam int DIGITS = N / 2 + 1;
    localparam int CW     = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [LANES-1:0]    en_q, en_d;
    logic [XW-1:0]       mcand_q [LANES];
    logic [XW-1:0]       mcand_d [LANES];
    logic [HW-1:0]       hi_q [LANES];
    logic [HW-1:0]       hi_d [LANES];
    logic [XW-1:0]       lo_q [LANES];     // multiplier bits, shifted out as product bits shift in
    logic [XW-1:0]       lo_d [LANES];
    logic [LANES-1:0]    prev_q, prev_d;   // Booth bit below the current digit
    logic [LANES*2*N-1:0] products_q, products_d;
    logic [HW+XW-1:0]    step_full [LANES];

    logic accept;
    logic last;

    assign accept = start && (state_q != CALC);
    assign last   = (state_q == CALC) && (cnt_q == CW'(DIGITS - 1));

    // One Booth step per lane: add digit x multiplicand to the upper half,
    // then arithmetic-shift the whole {hi, lo} pair right by two.
    always_comb begin : step_calc
        logic [HW-1:0]    mext;
        logic [HW-1:0]    addend;
        logic [HW-1:0]    sum;
        logic [HW+XW-1:0] pre;
        mext   = '0;
        addend = '0;
        sum    = '0;
        pre    = '0;
        for (int i = 0; i < LANES; i++) begin
            mext = {{2{mcand_q[i][XW-1]}}, mcand_q[i]};
            case ({lo_q[i][1:0], prev_q[i]})
                3'b001, 3'b010: addend = mext;
                3'b011:         addend = mext << 1;
                3'b100:         addend = -(mext << 1);
                3'b101, 3'b110: addend = -mext;
                default:        addend = '0;
            endcase
            sum          = hi_q[i] + addend;
            pre          = {sum, lo_q[i]};
            step_full[i] = $signed(pre) >>> 2;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        en_d       = en_q;
        mcand_d    = mcand_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        prev_d     = prev_q;
        products_d = products_q;

        case (state_q)
            IDLE: if (start) state_d = CALC;
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (last) state_d = DONE;
            end
            DONE: state_d = start ? CALC : IDLE;
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < LANES; i++) begin
            if (accept) begin
                // Disabled lanes load zeros and then never step, so they stay quiet.
                hi_d[i]    = '0;
                prev_d[i]  = 1'b0;
                mcand_d[i] = '0;
                lo_d[i]    = '0;
                if (lane_en[i]) begin
                    mcand_d[i] = signed_mode ? {{2{multiplicand[i*N+N-1]}}, multiplicand[i*N +: N]}
                                             : {2'b00, multiplicand[i*N +: N]};
                    lo_d[i]    = signed_mode ? {{2{multiplier[i*N+N-1]}}, multiplier[i*N +: N]}
                                             : {2'b00, multiplier[i*N +: N]};
                end
            end else if ((state_q == CALC) && en_q[i]) begin
                hi_d[i]   = step_full[i][HW+XW-1:XW];
                lo_d[i]   = step_full[i][XW-1:0];
                prev_d[i] = lo_q[i][1];
            end
            // The final step's result goes straight to products on the way into DONE.
            if (last) begin
                products_d[i*2*N +: 2*N] = en_q[i] ? step_full[i][2*N-1:0] : '0;
            end
        end

        if (accept) begin
            cnt_d = '0;
            en_d  = lane_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            en_q       <= '0;
            prev_q     <= '0;
            products_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                mcand_q[i] <= '0;
                hi_q[i]    <= '0;
                lo_q[i]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            prev_q     <= prev_d;
            products_q <= products_d;
            for (int i = 0; i < LANES; i++) begin
                mcand_q[i] <= mcand_d[i];
                hi_q[i]    <= hi_d[i];
                lo_q[i]    <= lo_d[i];
            end
        end
    end

    always_comb begin
        product_sel = '0;
        for (int i = 0; i < LANES; i++) begin
            if (sel == SW'(i)) product_sel = products_q[i*2*N +: 2*N];
        end
    end

    assign busy     = (state_q == CALC);
    assign done     = (state_q == DONE);
    assign products = products_q;

endmodule

// File: doc/booth_lane_array.md
BOOTH_LANE_ARRAY -- requirements
Module: booth_lane_array

Interface
REQ-001 SHALL have parameter N, default 16: operand width; even, >= 4.
REQ-002 SHALL have parameter LANES, default 4: number of independent multiplier lanes, >= 1.
REQ-003 SHALL use SW = max(1, clog2(LANES)) as the width of sel.
REQ-004 SHALL have ports:
- clk  input  1: clock, rising edge.
- rst_n  input  1: reset, asynchronous, active-low.
- start  input  1: request a new operation on all enabled lanes.
- signed_mode  input  1: 1 = two's-complement operands, 0 = unsigned; sampled with start.
- lane_en  input  LANES: per-lane enable; sampled with start.
- multiplicand  input  LANES*N: lane i in bits [i*N +: N].
- multiplier  input  LANES*N: lane i in bits [i*N +: N].
- sel  input  SW: lane selector for product_sel.
- busy  output  1: operation in progress.
- done  output  1: one-cycle result-valid pulse.
- products  output  LANES*2N: lane i in bits [i*2N +: 2N].
- product_sel  output  2N: products lane sel, combinational.

Function
REQ-005 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-006 SHALL accept start only in IDLE or DONE.
- On acceptance: latch operands, signed_mode and lane_en; clear the iteration counter and lane accumulators; go to CALC.
REQ-007 SHALL ignore start while in CALC: no relatch and no restart.
REQ-008 SHALL, per lane, extend both operands to N+2 bits: sign-extend when signed_mode=1, zero-extend when 0.
REQ-009 SHALL process one radix-4 Booth digit per cycle per lane, LSB first, appending an implicit 0 below the multiplier LSB.
- Digit {-2,-1,0,+1,+2} x extended multiplicand is added to the accumulator.
- Accumulator then shifts 2 bits arithmetically.
REQ-010 SHALL remain in CALC for exactly N/2+1 cycles, then go to DONE.
REQ-011 SHALL hold DONE for one cycle, then go to IDLE unless start is accepted in that cycle.
REQ-012 SHALL assert done only in DONE, so done is high in the (N/2+2)th cycle after the start-sampling edge (10 cycles for N=16).
REQ-013 SHALL drive busy = (state == CALC).
REQ-014 SHALL update products only on the CALC-to-DONE transition, with the exact 2N-bit product of every enabled lane.
- Values hold until the next such transition.
- No overflow is possible; the full signed and unsigned range is exact.
REQ-015 SHALL, for lanes disabled at start, hold the accumulator static (no toggling) and write 0 to that lane of products at the CALC-to-DONE transition.
REQ-016 SHALL, when sel >= LANES, drive product_sel to 0.
REQ-017 SHALL, on back-to-back operation, pulse done in the DONE cycle while the new start is accepted in that same cycle, giving one result per N/2+2 cycles.
- The products update of REQ-014 and the start acceptance of REQ-006 both take effect at the end of that DONE cycle.
REQ-018 SHALL treat all lanes as lock-step: one shared FSM, one shared counter and one done.

Reset
REQ-019 SHALL, on rst_n low at any time including mid-CALC, asynchronously force:
- state to IDLE;
- busy, done, products and all accumulators and counters to 0.
REQ-020 SHALL, after rst_n deasserts, accept start on the first rising edge.
- No partial result from an aborted operation is ever produced.

Verification
REQ-021 Unsigned max (N=16, LANES=4, all lanes on): lane0 0xFFFF x 0xFFFF, signed_mode=0 -> done in cycle 10; lane0 = 0xFFFE0001.
REQ-022 Signed corners, signed_mode=1 -> done in cycle 10:
- lanes 0x8000x0x8000, 0xFFFFx0x0003, 0x7FFFx0x8000, 0x0000x0x1234
- products 0x40000000, 0xFFFFFFFD, 0xC0008000, 0x00000000.
REQ-023 Lane masking: lane_en=4'b0101 with nonzero operands on all lanes -> lanes 1 and 3 = 0; lanes 0 and 2 correct; sel=1 gives product_sel=0; sel=2 gives lane 2.
REQ-024 Start in CALC ignored: start pulses at cycles 0 and 3 with different operands -> exactly one done, in cycle 10, carrying the cycle-0 operands.
REQ-025 Back-to-back: start held high continuously -> done every 10 cycles; each result matches the operands sampled at its own start.
REQ-026 Reset mid-operation: rst_n low in cycle 5 -> busy, done and products read 0 immediately; no done appears; the next start yields the correct result at cycle 10.
